// File: rtl/finn_feeder_chiplet_8_bits_mul_sxu_pipe.sv
// Multi-lane signed x unsigned multiplier pipeline with valid/ready flow control.
// Optional saturation and per-lane sticky overflow flags are computed at the output end.
module finn_feeder_chiplet_8_bits_mul_sxu_pipe #(
  parameter int LANES      = 1,
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 2,
  parameter int SAT_MODE   = 0
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DIN0_WIDTH-1:0]   din0,
  input  logic [LANES*DIN1_WIDTH-1:0]   din1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DOUT_WIDTH-1:0]   dout,
  output logic [LANES-1:0]              ovf,
  input  logic                          ovf_clr
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int EW = ((PW > DOUT_WIDTH) ? PW : DOUT_WIDTH) + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic                       advance;
  logic [NUM_STAGE-1:0]       vld;
  logic [LANES*PW-1:0]        prod;
  logic [LANES*PW-1:0]        pre_last;
  logic [LANES*DOUT_WIDTH-1:0] lane_res;
  logic [LANES-1:0]           lane_ovf;
  logic [LANES-1:0]           last_ovf;
  logic [LANES-1:0]           set_mask;

  // The whole pipeline moves as one unit; a stalled output freezes every stage.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = ap_rst_n && advance;
  assign out_valid = vld[NUM_STAGE-1];

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    assign a_ext = {{DIN1_WIDTH{din0[i*DIN0_WIDTH+DIN0_WIDTH-1]}}, din0[i*DIN0_WIDTH +: DIN0_WIDTH]};
    assign b_ext = {{DIN0_WIDTH{1'b0}}, din1[i*DIN1_WIDTH +: DIN1_WIDTH]};
    assign prod[i*PW +: PW] = a_ext * b_ext;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's old value.
      vld[0] <= in_valid;
      for (int s = 1; s < NUM_STAGE; s++) vld[s] <= vld[s-1];
    end
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign pre_last = prod;
  end else begin : g_mid
    logic [LANES*PW-1:0] mid_q [NUM_STAGE-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        // NOTE: the stage array is small, so it is reset too; no X ever reaches dout.
        for (int s = 0; s < NUM_STAGE-1; s++) mid_q[s] <= '0;
      end else if (advance) begin
        mid_q[0] <= prod;
        for (int s = 1; s < NUM_STAGE-1; s++) mid_q[s] <= mid_q[s-1];
      end
    end

    assign pre_last = mid_q[NUM_STAGE-2];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_sat
    logic signed [EW-1:0] p_ext;
    assign p_ext = {{(EW-PW){pre_last[i*PW+PW-1]}}, pre_last[i*PW +: PW]};
    assign lane_ovf[i] = (p_ext > MAX_V) || (p_ext < MIN_V);
    assign lane_res[i*DOUT_WIDTH +: DOUT_WIDTH] =
      ((SAT_MODE != 0) && lane_ovf[i]) ? (p_ext[EW-1] ? MIN_V[DOUT_WIDTH-1:0] : MAX_V[DOUT_WIDTH-1:0])
                                       : p_ext[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout     <= '0;
      last_ovf <= '0;
    end else if (advance) begin
      dout     <= lane_res;
      last_ovf <= lane_ovf;
    end
  end

  // A flag is raised only when its beat actually leaves; a simultaneous set beats the clear.
  assign set_mask = (out_valid && out_ready) ? last_ovf : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf_clr ? '0 : ovf) | set_mask;
    end
  end

endmodule

// File: tb/tb_finn_feeder_chiplet_8_bits_mul_sxu_pipe.sv
// Bench for the multiplier pipeline: three configurations against a queue-based product model,
// plus directed beats with hand-computed results.
module tb_finn_feeder_chiplet_8_bits_mul_sxu_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  o;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;
  logic [13:0] a0;
  logic [11:0] b0;
  logic [55:0] a4;
  logic [47:0] b4;

  logic        ir0, ov0, ovf0;
  logic [25:0] dout0;
  logic        ir1, ov1, ir2, ov2;
  logic [63:0] dout1, dout2;
  logic [3:0]  ovf1, ovf2;

  logic [2:0]  ov_v, ir_v;
  logic [63:0] dv [3];
  logic [3:0]  ovv [3];

  int checks   = 0;
  int failures = 0;

  beat_t fifo [3][64];
  int    wp [3];
  int    rp [3];
  int    acc [3];
  logic [3:0]  ovf_m [3];
  logic        stall [3];
  logic [63:0] prev_d [3];

  // Defaults: one lane, two stages, 26-bit wrap.
  finn_feeder_chiplet_8_bits_mul_sxu_pipe u0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .din0(a0), .din1(b0), .out_valid(ov0), .out_ready(out_ready),
    .dout(dout0), .ovf(ovf0), .ovf_clr(ovf_clr));

  // Four lanes, three stages, 16-bit saturate.
  finn_feeder_chiplet_8_bits_mul_sxu_pipe #(.LANES(4), .DOUT_WIDTH(16), .NUM_STAGE(3), .SAT_MODE(1)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .din0(a4), .din1(b4), .out_valid(ov1), .out_ready(out_ready),
    .dout(dout1), .ovf(ovf1), .ovf_clr(ovf_clr));

  // Four lanes, two stages, 16-bit wrap.
  finn_feeder_chiplet_8_bits_mul_sxu_pipe #(.LANES(4), .DOUT_WIDTH(16), .NUM_STAGE(2), .SAT_MODE(0)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .din0(a4), .din1(b4), .out_valid(ov2), .out_ready(out_ready),
    .dout(dout2), .ovf(ovf2), .ovf_clr(ovf_clr));

  assign ov_v   = {ov2, ov1, ov0};
  assign ir_v   = {ir2, ir1, ir0};
  assign dv[0]  = {38'd0, dout0};
  assign dv[1]  = dout1;
  assign dv[2]  = dout2;
  assign ovv[0] = {3'd0, ovf0};
  assign ovv[1] = ovf1;
  assign ovv[2] = ovf2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected result of one beat: exact product, then wrap or clamp to the output width.
  function automatic beat_t model(input int d);
    beat_t  r;
    int     lanes, dw;
    bit     sat;
    longint pa, pb, p, hi, lo, v;
    logic [63:0] mask;
    lanes = (d == 0) ? 1 : 4;
    dw    = (d == 0) ? 26 : 16;
    sat   = (d == 1);
    hi    = (longint'(1) <<< (dw - 1)) - 1;
    lo    = -(longint'(1) <<< (dw - 1));
    mask  = (64'd1 << dw) - 64'd1;
    r     = '0;
    for (int i = 0; i < lanes; i++) begin
      if (d == 0) begin
        pa = longint'($signed(a0));
        pb = longint'(b0);
      end else begin
        pa = longint'($signed(a4[i*14 +: 14]));
        pb = longint'(b4[i*12 +: 12]);
      end
      p = pa * pb;
      v = p;
      if (p > hi || p < lo) begin
        r.o[i] = 1'b1;
        if (sat) v = (p > 0) ? hi : lo;
      end
      r.d = r.d | ((64'(v) & mask) << (i * dw));
    end
    return r;
  endfunction

  // Compare process: inputs change just after rising edges, so everything is stable here.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        check($sformatf("rst_valid%0d", d), ov_v[d], 0);
        check($sformatf("rst_dout%0d", d), dv[d], 0);
        check($sformatf("rst_ovf%0d", d), ovv[d], 0);
        check($sformatf("rst_ready%0d", d), ir_v[d], 0);
        wp[d] = 0; rp[d] = 0; ovf_m[d] = '0; stall[d] = 0;
      end else begin
        logic [3:0] om;
        om = '0;
        check($sformatf("ovf%0d", d), ovv[d], ovf_m[d]);
        check($sformatf("in_ready%0d", d), ir_v[d], !ov_v[d] || out_ready);
        if (stall[d]) begin
          check($sformatf("hold_valid%0d", d), ov_v[d], 1);
          check($sformatf("hold_dout%0d", d), dv[d], prev_d[d]);
        end
        if (ov_v[d] && out_ready) begin
          if (wp[d] == rp[d]) begin
            check($sformatf("spurious_out%0d", d), 1, 0);
          end else begin
            check($sformatf("dout%0d", d), dv[d], fifo[d][rp[d] % 64].d);
            om = fifo[d][rp[d] % 64].o;
            rp[d]++;
          end
        end
        ovf_m[d] = (ovf_clr ? 4'd0 : ovf_m[d]) | om;
        stall[d]  = ov_v[d] && !out_ready;
        prev_d[d] = dv[d];
        if (in_valid && ir_v[d]) begin
          fifo[d][wp[d] % 64] = model(d);
          wp[d]++;
          acc[d]++;
        end
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec();
    a0 = 14'h3FFD;  // -3
    b0 = 12'd5;
    a4 = {14'h1FFF, 14'h0064, 14'h3FFD, 14'h2000};  // 8191, 100, -3, -8192
    b4 = {12'hFFF, 12'h0C8, 12'h005, 12'hFFF};      // 4095, 200, 5, 4095
  endtask

  initial begin
    int s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a0 = '0; b0 = '0; a4 = '0; b4 = '0;
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0; rp[d] = 0; acc[d] = 0; ovf_m[d] = '0; stall[d] = 0; prev_d[d] = '0;
    end
    nc(); nc();
    @(negedge clk);
    check("reset_out_valid", ov0, 0);
    check("reset_in_ready", ir0, 0);

    // Directed beat, accepted on the first edge after reset release.
    nc();
    rst_n = 1'b1; in_valid = 1'b1; load_vec();
    nc();
    in_valid = 1'b0;
    @(negedge clk);
    check("u0_not_yet", ov0, 0);
    check("u2_not_yet", ov2, 0);
    nc();
    @(negedge clk);
    check("u0_latency2", ov0, 1);
    check("u0_dout_m15", dout0, 26'h3FFFFF1);
    check("u2_latency2", ov2, 1);
    check("u2_wrap_dout", dout2, 64'hD001_4E20_FFF1_2000);
    check("u1_not_yet", ov1, 0);
    nc();
    @(negedge clk);
    check("u1_latency3", ov1, 1);
    check("u1_sat_dout", dout1, 64'h7FFF_4E20_FFF1_8000);
    check("u2_ovf_set", ovf2, 4'b1001);
    check("u0_ovf_clear", ovf0, 0);
    nc();
    ovf_clr = 1'b1;
    @(negedge clk);
    check("u1_ovf_set", ovf1, 4'b1001);
    nc();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("u1_ovf_cleared", ovf1, 0);
    check("u2_ovf_cleared", ovf2, 0);

    // Overflowing beat leaves u2 on the same edge as a clear pulse: set wins.
    nc();
    in_valid = 1'b1; load_vec();
    nc();
    in_valid = 1'b0;
    nc();
    ovf_clr = 1'b1;
    nc();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("set_wins_u2", ovf2, 4'b1001);
    nc();
    @(negedge clk);
    check("u1_ovf_after", ovf1, 4'b1001);

    // Two beats in flight, then reset.
    nc();
    out_ready = 1'b0; in_valid = 1'b1; a4 = 56'h0123_4567_89AB_CD; b4 = 48'h1234_5678_9ABC;
    nc();
    a4 = 56'hFEDC_BA98_7654_32;
    nc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", ov1, 0);
    check("midrst_dout", dout1, 0);
    check("midrst_ovf", ovf1, 0);
    nc();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a0 = 14'd7; b0 = 12'd3;
    nc();
    in_valid = 1'b0;
    nc();
    @(negedge clk);
    check("postrst_first_valid", ov0, 1);
    check("postrst_first_dout", dout0, 26'd21);

    // Random stream with pseudo-random back-pressure.
    s = acc[1];
    for (int c = 0; c < 80; c++) begin
      nc();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      a0 = 14'($urandom());
      b0 = 12'($urandom());
      a4 = 56'({$urandom(), $urandom()});
      b4 = 48'({$urandom(), $urandom()});
    end
    nc();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) nc();
    @(negedge clk);
    check("stream_beats_u1", (acc[1] - s) >= 10, 1);
    for (int d = 0; d < 3; d++) check($sformatf("drained%0d", d), 64'(wp[d] - rp[d]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/finn_feeder_chiplet_8_bits_mul_sxu_pipe.md
FINN_FEEDER_CHIPLET_8_BITS_MUL_SXU_PIPE -- requirements
Module: finn_feeder_chiplet_8_bits_mul_sxu_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1: number of independent multiplier lanes (>=1).
REQ-002 SHALL have parameter DIN0_WIDTH, default 14: width of each signed lane operand A.
REQ-003 SHALL have parameter DIN1_WIDTH, default 12: width of each unsigned lane operand B.
REQ-004 SHALL have parameter DOUT_WIDTH, default 26: width of each signed lane result.
REQ-005 SHALL have parameter NUM_STAGE, default 2: register stages from input to output (>=1).
REQ-006 SHALL have parameter SAT_MODE, default 0: 0 = wrap (keep low bits), 1 = saturate to signed DOUT_WIDTH.
REQ-007 SHALL have port ap_clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1: input beat present.
REQ-010 SHALL have port in_ready, output, 1: block accepts an input beat this cycle.
REQ-011 SHALL have port din0, input, LANES*DIN0_WIDTH: lane i operand A in bits [i*DIN0_WIDTH +: DIN0_WIDTH], signed.
REQ-012 SHALL have port din1, input, LANES*DIN1_WIDTH: lane i operand B in bits [i*DIN1_WIDTH +: DIN1_WIDTH], unsigned.
REQ-013 SHALL have port out_valid, output, 1: output beat present.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the output beat.
REQ-015 SHALL have port dout, output, LANES*DOUT_WIDTH: lane i result in bits [i*DOUT_WIDTH +: DOUT_WIDTH].
REQ-016 SHALL have port ovf, output, LANES: per-lane sticky overflow flag.
REQ-017 SHALL have port ovf_clr, input, 1: synchronous clear of all ovf bits.

Function
REQ-018 SHALL compute per lane the full product P = signed(A) * signed({1'b0, B}), exact width DIN0_WIDTH+DIN1_WIDTH.
REQ-019 SHALL, with SAT_MODE=0, output the low DOUT_WIDTH bits of P; if DOUT_WIDTH exceeds the product width, P is sign-extended.
REQ-020 SHALL, with SAT_MODE=1, clamp P to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
REQ-021 SHALL flag lane overflow when P lies outside the signed DOUT_WIDTH range, in either mode.
REQ-022 SHALL form the pipeline as NUM_STAGE registered stages, each holding a valid bit, per-lane data and per-lane overflow; the product is computed ahead of stage 1, and saturation and overflow detection ahead of the last stage.
REQ-023 SHALL define advance = !out_valid || out_ready, and drive in_ready = advance while ap_rst_n is high (combinational, no input-to-ready path other than through out_ready).
REQ-024 SHALL accept an input beat iff in_valid && in_ready; when advance is high, all stages shift by one and stage 1 loads (in_valid, data).
REQ-025 SHALL hold every stage (valid and data) unchanged while advance is low; no beat is lost or duplicated.
REQ-026 SHALL present each accepted beat on dout/out_valid exactly NUM_STAGE cycles after acceptance when out_ready stays high; throughput is 1 beat per cycle.
REQ-027 SHALL keep dout stable while out_valid && !out_ready.
REQ-028 SHALL let bubbles (in_valid low on an advance) propagate as valid=0 stages; out_valid reflects only the last stage.
REQ-029 SHALL set ovf[i] on the cycle a beat with lane-i overflow completes transfer (out_valid && out_ready); ovf[i] stays set until cleared.
REQ-030 SHALL clear all ovf bits on a cycle with ovf_clr high; when a set and a clear occur in the same cycle, the bit ends at 1 (set wins).
REQ-031 SHALL treat lanes identically and independently; lane data never crosses lanes.

Reset
REQ-032 SHALL, while ap_rst_n is low, force all stage valid bits, out_valid, dout and ovf to 0, with in_ready at 0.
REQ-033 SHALL discard all in-flight beats when reset is asserted mid-operation; after release, the first output is the first beat accepted post-reset.
REQ-034 SHALL accept input on the first rising edge on which ap_rst_n is high.

Verification
REQ-035 Defaults, LANES=1, din0=-3 (0x3FFD), din1=5, out_ready=1 -> dout=-15, out_valid 2 cycles after acceptance, ovf=0.
REQ-036 DOUT_WIDTH=16, SAT_MODE=1, din0=-8192, din1=4095 -> dout=-32768 (0x8000), ovf=1; then ovf_clr pulse -> ovf=0.
REQ-037 Same as REQ-036 but SAT_MODE=0 -> dout=0x2000, ovf=1.
REQ-038 LANES=4, NUM_STAGE=3, stream of 10 beats, out_ready toggled pseudo-randomly -> all 10 results in order, each equal to its reference product, dout stable while stalled, in_ready=0 whenever out_valid && !out_ready.
REQ-039 Assert ap_rst_n low with 2 beats in flight -> out_valid=0, dout=0 and ovf=0 immediately; after release, the next accepted beat is the first output.
REQ-040 Overflowing beat transferring in the same cycle as an ovf_clr pulse -> ovf=1 afterwards.
